// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, defaults and helpers for the round-robin arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    REL   = 2'd2
  } arb_state_t;

  localparam int DEF_N        = 8;
  localparam int DEF_MAX_HOLD = 16;

  // Ceiling log2; clog2(1) returns 0, callers clamp to at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_enc8.sv
// rtl/onehot_enc8.sv - combinational 8-to-3 OR encoder for a one-hot (or zero) vector
module onehot_enc8 (
  input  logic [7:0] onehot,
  output logic [2:0] idx
);

  // Each index bit is the OR of the one-hot positions that have that bit set;
  // a zero input therefore encodes to index 0.
  assign idx[0] = onehot[1] | onehot[3] | onehot[5] | onehot[7];
  assign idx[1] = onehot[2] | onehot[3] | onehot[6] | onehot[7];
  assign idx[2] = onehot[4] | onehot[5] | onehot[6] | onehot[7];

endmodule

// File: rtl/rr_arb_enc8.sv
// rtl/rr_arb_enc8.sv - round-robin arbiter with registered one-hot grant, hold timeout and binary index
module rr_arb_enc8
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  // Hold counter must represent 0..MAX_HOLD; keep at least one bit when the timeout is disabled.
  localparam int CNT_RAW = clog2(MAX_HOLD + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             timeout_c;
  logic             hold_last;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [7:0]       enc_in;
  logic [2:0]       enc_idx;
  int               scan;

  // Pad the grant to the encoder's fixed 8-bit width; unused positions stay zero.
  always_comb begin
    enc_in        = '0;
    enc_in[N-1:0] = gnt;
  end

  onehot_enc8 u_enc (
    .onehot (enc_in),
    .idx    (enc_idx)
  );

  assign gnt_idx = IDX_W'(enc_idx);

  // Last permitted hold cycle; never true when the timeout is disabled.
  assign hold_last = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Rotating priority pick: first set request starting at ptr, wrapping mod N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < N; k++) begin
      scan = (int'(ptr) + k) % N;
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan);
      end
    end
  end

  // Next-state, next-grant, pointer and hold-counter logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    timeout_c = 1'b0;
    case (state)
      IDLE: begin
        if (en && win_found) begin
          gnt_nxt          = '0;
          gnt_nxt[win_idx] = 1'b1;
          hold_nxt         = '0;
          state_nxt        = GRANT;
        end
      end
      GRANT: begin
        // A requester dropping req wins over a coincident timeout: normal release.
        if (!req[gnt_idx] || hold_last) begin
          timeout_c = req[gnt_idx];
          gnt_nxt   = '0;
          ptr_nxt   = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
          state_nxt = REL;
        end else if (hold_cnt != {CNT_W{1'b1}}) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      REL: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // A reset edge releases without reporting a forced release.
  assign timeout = timeout_c & rst_n;

  // State, grant, pointer and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb_enc8.sv
// tb/tb_rr_arb_enc8.sv - self-checking bench for rr_arb_enc8 with vector table and corner sequences
module tb_rr_arb_enc8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;

  int checks;
  int failures;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       to;
  } vec_t;

  vec_t tbl [27];

  rr_arb_enc8 #(.N(8), .IDX_W(3), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // One cycle: drive inputs at the falling edge, compare the outputs of that cycle.
  task automatic cyc(input logic r, input logic e, input logic [7:0] rq,
                     input logic [7:0] eg, input logic eto, input string nm);
    logic [2:0] ei;
    logic       ev;
    @(negedge clk);
    rst_n = r;
    en    = e;
    req   = rq;
    #1;
    ei = idx_of(eg);
    ev = (eg != 8'h00);
    checks++;
    if (gnt !== eg || gnt_valid !== ev || gnt_idx !== ei || timeout !== eto) begin
      failures++;
      $display("FAIL %s: gnt=%h valid=%b idx=%0d timeout=%b, expected gnt=%h valid=%b idx=%0d timeout=%b",
               nm, gnt, gnt_valid, gnt_idx, timeout, eg, ev, ei, eto);
    end
  endtask

  initial begin
    logic [7:0] bit_o;
    logic [7:0] idle_req;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = 8'h00;

    // reset/idle, en gating, reset mid-grant
    tbl[0]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h00, 8'h01, 1'b0};
    for (int i = 4; i < 14; i++) tbl[i] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 8'h10, 8'h00, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h10, 8'h10, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 8'h10, 8'h10, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 8'h10, 8'h10, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 8'h10, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 8'h40, 8'h00, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 8'h40, 8'h40, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 8'h40, 8'h40, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 8'h41, 8'h00, 1'b0};
    tbl[24] = '{1'b1, 1'b1, 8'h41, 8'h01, 1'b0};
    tbl[25] = '{1'b0, 1'b1, 8'hFF, 8'h01, 1'b0};
    tbl[26] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};

    for (int i = 0; i < 27; i++)
      cyc(tbl[i].rst_n, tbl[i].en, tbl[i].req, tbl[i].gnt, tbl[i].to, $sformatf("vec%0d", i));

    // rotation 0..7,0; each owner holds two cycles then drops its req
    for (int o = 0; o < 9; o++) begin
      bit_o    = 8'h01 << (o % 8);
      idle_req = (o == 8) ? 8'h24 : 8'hFF;
      cyc(1'b1, 1'b1, 8'hFF,          bit_o, 1'b0, $sformatf("rot%0d_a", o));
      cyc(1'b1, 1'b1, 8'hFF,          bit_o, 1'b0, $sformatf("rot%0d_b", o));
      cyc(1'b1, 1'b1, 8'hFF & ~bit_o, bit_o, 1'b0, $sformatf("rot%0d_drop", o));
      cyc(1'b1, 1'b1, idle_req,       8'h00, 1'b0, $sformatf("rot%0d_rel", o));
      cyc(1'b1, 1'b1, idle_req,       8'h00, 1'b0, $sformatf("rot%0d_idle", o));
    end

    // timeout on idx 2, then idx 5, then idx 2 again
    for (int k = 0; k < 16; k++)
      cyc(1'b1, 1'b1, 8'h24, 8'h04, (k == 15), $sformatf("to2_k%0d", k));
    cyc(1'b1, 1'b1, 8'h24, 8'h00, 1'b0, "to2_rel");
    cyc(1'b1, 1'b1, 8'h24, 8'h00, 1'b0, "to2_idle");
    for (int k = 0; k < 16; k++)
      cyc(1'b1, 1'b1, 8'h24, 8'h20, (k == 15), $sformatf("to5_k%0d", k));
    cyc(1'b1, 1'b1, 8'h24, 8'h00, 1'b0, "to5_rel");
    cyc(1'b1, 1'b1, 8'h24, 8'h00, 1'b0, "to5_idle");

    // idx 2 re-granted; req[2] drops on hold_cnt=15 -> normal release, ptr=3
    for (int k = 0; k < 16; k++)
      cyc(1'b1, 1'b1, (k == 15) ? 8'h20 : 8'h24, 8'h04, 1'b0, $sformatf("col_k%0d", k));
    cyc(1'b1, 1'b1, 8'h2C, 8'h00, 1'b0, "col_rel");
    cyc(1'b1, 1'b1, 8'h2C, 8'h00, 1'b0, "col_idle");
    cyc(1'b1, 1'b1, 8'h00, 8'h08, 1'b0, "col_ptr3");
    cyc(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, "col_end_rel");
    cyc(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, "col_end_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
